pmc_frame_sched: RTL

PMC_FRAME_SCHED -- requirements
Module: pmc_frame_sched

---
 rtl/pmc_frame_sched.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pmc_frame_sched.sv
// Frame scheduler for the pmcc: arms, triggers, waits for frame completion and
// spaces frames by a programmable gap. Optional watchdog under PMC_FRAME_SCHED_WDT_EN.
module pmc_frame_sched #(
    parameter int PERIOD_W    = 24,
    parameter int FRAME_W     = 16,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_en,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [FRAME_W-1:0]  cfg_frames,
    input  logic                err_clr,
    input  logic                pmcc_wait,
    output logic                trg,
    output logic                pmcc_rst_req,
    output logic                busy,
    output logic                done,
    output logic [FRAME_W-1:0]  frame_cnt,
    output logic                timeout_err
);

    typedef enum logic [2:0] {IDLE, ARM, TRIG, RUN, GAP} state_t;

    state_t              state, state_nx;
    logic [PERIOD_W-1:0] per_sh, gap_cnt, gap_cnt_nx;
    logic [FRAME_W-1:0]  frm_sh, cnt_nx, cnt_inc;
    logic                seen_busy, seen_busy_nx;
    logic                ld_shadow, done_nx, rst_req_nx, wdt_hit, stop;

    assign stop    = cfg_abort | ~cfg_en;
    assign cnt_inc = frame_cnt + FRAME_W'(1);
    assign busy    = (state != IDLE);

    always_comb begin
        state_nx     = state;
        gap_cnt_nx   = gap_cnt;
        seen_busy_nx = seen_busy;
        cnt_nx       = frame_cnt;
        ld_shadow    = 1'b0;
        done_nx      = 1'b0;
        rst_req_nx   = 1'b0;
        if (stop) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (cfg_start) begin
                    ld_shadow = 1'b1;
                    cnt_nx    = '0;
                    state_nx  = ARM;
                end
                ARM: if (pmcc_wait) state_nx = TRIG;
                TRIG: begin
                    seen_busy_nx = 1'b0;
                    state_nx     = RUN;
                end
                RUN: begin
                    // A frame is only complete once the pmcc has been seen busy.
                    if (seen_busy && pmcc_wait) begin
                        cnt_nx = cnt_inc;
                        if (frm_sh != '0 && cnt_inc == frm_sh) begin
                            done_nx  = 1'b1;
                            state_nx = IDLE;
                        end else begin
                            gap_cnt_nx = per_sh;
                            state_nx   = GAP;
                        end
                    end else begin
                        if (!pmcc_wait) seen_busy_nx = 1'b1;
                        if (wdt_hit) begin
                            rst_req_nx = 1'b1;
                            state_nx   = IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state_nx = ARM;
                    else               gap_cnt_nx = gap_cnt - PERIOD_W'(1);
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            per_sh    <= '0;
            frm_sh    <= '0;
            gap_cnt   <= '0;
            seen_busy <= 1'b0;
            frame_cnt <= '0;
            trg       <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            gap_cnt   <= gap_cnt_nx;
            seen_busy <= seen_busy_nx;
            frame_cnt <= cnt_nx;
            trg       <= (state_nx == TRIG);
            done      <= done_nx;
            if (ld_shadow) begin
                per_sh <= cfg_period;
                frm_sh <= cfg_frames;
            end
        end
    end

`ifdef PMC_FRAME_SCHED_WDT_EN
    localparam int WDT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WDT_W-1:0] wdt_cnt;

    // Counts cycles spent in the current RUN visit; restarts on every entry.
    assign wdt_hit = (state == RUN) && (wdt_cnt == WDT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt      <= '0;
            pmcc_rst_req <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            wdt_cnt      <= (state == RUN) ? wdt_cnt + WDT_W'(1) : '0;
            pmcc_rst_req <= rst_req_nx;
            if (rst_req_nx)   timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end
`else
    logic unused_wdt;
    assign wdt_hit      = 1'b0;
    assign pmcc_rst_req = 1'b0;
    assign timeout_err  = 1'b0;
    assign unused_wdt   = err_clr ^ rst_req_nx ^ (TIMEOUT_CYC == 0);
`endif

endmodule
